// File: rtl/multicycle_ctrl.sv
// Main control FSM of the multicycle MIPS core: sequences fetch, decode,
// execute, memory and writeback, driving ALU command, mux selects and enables.
module multicycle_ctrl #(
  parameter int ALU_CMD_W = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [5:0]           opcode,
  input  logic [5:0]           funct,
  input  logic                 zero,
  input  logic                 mem_ready,
  output logic [ALU_CMD_W-1:0] alu_cmd,
  output logic [1:0]           alu_src_a,
  output logic [2:0]           alu_src_b,
  output logic                 mem_req,
  output logic                 mem_we,
  output logic                 i_or_d,
  output logic                 ir_write,
  output logic                 pc_write,
  output logic [1:0]           pc_src,
  output logic                 reg_write,
  output logic                 reg_dst,
  output logic                 mem_to_reg,
  output logic                 illegal,
  output logic [3:0]           state_out
);

  typedef enum logic [3:0] {
    S_IDLE      = 4'd0,
    S_FETCH     = 4'd1,
    S_DECODE    = 4'd2,
    S_MEM_ADDR  = 4'd3,
    S_MEM_READ  = 4'd4,
    S_MEM_WB    = 4'd5,
    S_MEM_WRITE = 4'd6,
    S_R_EXEC    = 4'd7,
    S_R_WB      = 4'd8,
    S_I_EXEC    = 4'd9,
    S_I_WB      = 4'd10,
    S_BRANCH    = 4'd11,
    S_JUMP      = 4'd12,
    S_ILLEGAL   = 4'd13
  } state_t;

  localparam logic [ALU_CMD_W-1:0] CMD_ADD = ALU_CMD_W'(4'b0000);
  localparam logic [ALU_CMD_W-1:0] CMD_SUB = ALU_CMD_W'(4'b0010);
  localparam logic [ALU_CMD_W-1:0] CMD_AND = ALU_CMD_W'(4'b0100);
  localparam logic [ALU_CMD_W-1:0] CMD_OR  = ALU_CMD_W'(4'b0101);
  localparam logic [ALU_CMD_W-1:0] CMD_NOR = ALU_CMD_W'(4'b0110);
  localparam logic [ALU_CMD_W-1:0] CMD_XOR = ALU_CMD_W'(4'b0111);
  localparam logic [ALU_CMD_W-1:0] CMD_SLL = ALU_CMD_W'(4'b1000);
  localparam logic [ALU_CMD_W-1:0] CMD_SRA = ALU_CMD_W'(4'b1001);
  localparam logic [ALU_CMD_W-1:0] CMD_SRL = ALU_CMD_W'(4'b1010);

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_XORI  = 6'b001110;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_J     = 6'b000010;

  state_t state_q, state_d;

  logic [ALU_CMD_W-1:0] r_cmd;
  logic                 r_ok;
  logic                 r_shift;

  // R-type function decode, shared by DECODE (legality) and R_EXEC (command).
  always_comb begin
    r_cmd   = CMD_ADD;
    r_ok    = 1'b1;
    r_shift = 1'b0;
    case (funct)
      6'b100000: r_cmd = CMD_ADD;
      6'b100010: r_cmd = CMD_SUB;
      6'b100100: r_cmd = CMD_AND;
      6'b100101: r_cmd = CMD_OR;
      6'b100111: r_cmd = CMD_NOR;
      6'b100110: r_cmd = CMD_XOR;
      6'b000000: begin r_cmd = CMD_SLL; r_shift = 1'b1; end
      6'b000011: begin r_cmd = CMD_SRA; r_shift = 1'b1; end
      6'b000010: begin r_cmd = CMD_SRL; r_shift = 1'b1; end
      default:   r_ok = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= S_IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   state_d = S_FETCH;
      S_FETCH:  if (mem_ready) state_d = S_DECODE;
      S_DECODE: begin
        case (opcode)
          OP_LW, OP_SW:                      state_d = S_MEM_ADDR;
          OP_RTYPE:                          state_d = r_ok ? S_R_EXEC : S_ILLEGAL;
          OP_ADDI, OP_ANDI, OP_ORI, OP_XORI: state_d = S_I_EXEC;
          OP_BEQ, OP_BNE:                    state_d = S_BRANCH;
          OP_J:                              state_d = S_JUMP;
          default:                           state_d = S_ILLEGAL;
        endcase
      end
      S_MEM_ADDR:  state_d = (opcode == OP_SW) ? S_MEM_WRITE : S_MEM_READ;
      S_MEM_READ:  if (mem_ready) state_d = S_MEM_WB;
      S_MEM_WRITE: if (mem_ready) state_d = S_FETCH;
      S_R_EXEC:    state_d = S_R_WB;
      S_I_EXEC:    state_d = S_I_WB;
      S_MEM_WB, S_R_WB, S_I_WB, S_BRANCH, S_JUMP, S_ILLEGAL: state_d = S_FETCH;
      default:     state_d = S_IDLE;
    endcase
  end

  // Outputs are Moore except the FETCH enables and the BRANCH PC write.
  always_comb begin
    alu_cmd    = CMD_ADD;
    alu_src_a  = 2'b00;
    alu_src_b  = 3'b000;
    mem_req    = 1'b0;
    mem_we     = 1'b0;
    i_or_d     = 1'b0;
    ir_write   = 1'b0;
    pc_write   = 1'b0;
    pc_src     = 2'b00;
    reg_write  = 1'b0;
    reg_dst    = 1'b0;
    mem_to_reg = 1'b0;
    illegal    = 1'b0;
    case (state_q)
      S_FETCH: begin
        mem_req   = 1'b1;
        alu_src_b = 3'b001;
        ir_write  = mem_ready;
        pc_write  = mem_ready;
      end
      S_DECODE:   alu_src_b = 3'b011;
      S_MEM_ADDR: begin
        alu_src_a = 2'b01;
        alu_src_b = 3'b010;
      end
      S_MEM_READ: begin
        mem_req = 1'b1;
        i_or_d  = 1'b1;
      end
      S_MEM_WB: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
      end
      S_MEM_WRITE: begin
        mem_req = 1'b1;
        mem_we  = 1'b1;
        i_or_d  = 1'b1;
      end
      S_R_EXEC: begin
        alu_cmd   = r_cmd;
        alu_src_a = r_shift ? 2'b10 : 2'b01;
        alu_src_b = r_shift ? 3'b100 : 3'b000;
      end
      S_R_WB: begin
        reg_write = 1'b1;
        reg_dst   = 1'b1;
      end
      S_I_EXEC: begin
        alu_src_a = 2'b01;
        alu_src_b = 3'b101;
        case (opcode)
          OP_ANDI: alu_cmd = CMD_AND;
          OP_ORI:  alu_cmd = CMD_OR;
          OP_XORI: alu_cmd = CMD_XOR;
          default: begin
            alu_cmd   = CMD_ADD;
            alu_src_b = 3'b010;
          end
        endcase
      end
      S_I_WB: reg_write = 1'b1;
      S_BRANCH: begin
        alu_src_a = 2'b01;
        alu_cmd   = CMD_SUB;
        pc_src    = 2'b01;
        pc_write  = ((opcode == OP_BEQ) & zero) | ((opcode == OP_BNE) & ~zero);
      end
      S_JUMP: begin
        pc_write = 1'b1;
        pc_src   = 2'b10;
      end
      S_ILLEGAL: illegal = 1'b1;
      default: ;
    endcase
  end

  assign state_out = state_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Bench for multicycle_ctrl: per-instruction expected cycle traces built from
// the instruction rules, compared against the DUT every cycle.
module tb_multicycle_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [5:0] opcode = '0;
  logic [5:0] funct = '0;
  logic       zero = 1'b0;
  logic       mem_ready = 1'b0;
  logic [3:0] alu_cmd;
  logic [1:0] alu_src_a;
  logic [2:0] alu_src_b;
  logic       mem_req, mem_we, i_or_d, ir_write, pc_write;
  logic [1:0] pc_src;
  logic       reg_write, reg_dst, mem_to_reg, illegal;
  logic [3:0] state_out;

  multicycle_ctrl #(.ALU_CMD_W(4)) dut (
    .clk(clk), .rst(rst), .opcode(opcode), .funct(funct), .zero(zero),
    .mem_ready(mem_ready), .alu_cmd(alu_cmd), .alu_src_a(alu_src_a),
    .alu_src_b(alu_src_b), .mem_req(mem_req), .mem_we(mem_we), .i_or_d(i_or_d),
    .ir_write(ir_write), .pc_write(pc_write), .pc_src(pc_src),
    .reg_write(reg_write), .reg_dst(reg_dst), .mem_to_reg(mem_to_reg),
    .illegal(illegal), .state_out(state_out)
  );

  always #5 clk = ~clk;

  // Packed output vector: {state,cmd,src_a,src_b,req,we,iord,irw,pcw,pcsrc,rw,rdst,m2r,ill}
  logic [23:0] act;
  assign act = {state_out, alu_cmd, alu_src_a, alu_src_b, mem_req, mem_we, i_or_d,
                ir_write, pc_write, pc_src, reg_write, reg_dst, mem_to_reg, illegal};

  int n_tests = 0;
  int n_fail  = 0;

  logic [23:0] exp_q[$];
  logic [13:0] stim_q[$];  // {mem_ready, zero, opcode, funct}

  localparam int K_LW = 0, K_SW = 1, K_R = 2, K_I = 3, K_BR = 4, K_J = 5, K_ILL = 6;

  function automatic logic [23:0] pk(input logic [3:0] st, input logic [3:0] cmd,
      input logic [1:0] sa, input logic [2:0] sb, input logic req, input logic we,
      input logic iod, input logic irw, input logic pcw, input logic [1:0] pcs,
      input logic rw, input logic rd, input logic m2r, input logic ill);
    return {st, cmd, sa, sb, req, we, iod, irw, pcw, pcs, rw, rd, m2r, ill};
  endfunction

  function automatic int r_cmd(input logic [5:0] fn);
    case (fn)
      6'h20: return 0;
      6'h22: return 2;
      6'h24: return 4;
      6'h25: return 5;
      6'h27: return 6;
      6'h26: return 7;
      6'h00: return 8;
      6'h03: return 9;
      6'h02: return 10;
      default: return -1;
    endcase
  endfunction

  function automatic int kind(input logic [5:0] op, input logic [5:0] fn);
    case (op)
      6'b100011: return K_LW;
      6'b101011: return K_SW;
      6'b000000: return (r_cmd(fn) >= 0) ? K_R : K_ILL;
      6'b001000, 6'b001100, 6'b001101, 6'b001110: return K_I;
      6'b000100, 6'b000101: return K_BR;
      6'b000010: return K_J;
      default: return K_ILL;
    endcase
  endfunction

  task automatic check(input string name, input logic [23:0] got, input logic [23:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, got, exp, $time);
    end
  endtask

  task automatic check_int(input string name, input int got, input int exp);
    n_tests++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  task automatic push(input logic mr, input logic z, input logic [5:0] op,
                      input logic [5:0] fn, input logic [23:0] v);
    stim_q.push_back({mr, z, op, fn});
    exp_q.push_back(v);
  endtask

  // Expected cycle trace for one instruction with wf fetch and wm memory wait cycles.
  task automatic build(input logic [5:0] op, input logic [5:0] fn, input logic z,
                       input int wf, input int wm);
    int k;
    int c;
    logic pcw;
    logic rnd;
    k = kind(op, fn);
    for (int i = 0; i < wf; i++)
      push(1'b0, 1'($urandom_range(0, 1)), op, fn, pk(1, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    push(1'b1, 1'($urandom_range(0, 1)), op, fn, pk(1, 0, 0, 1, 1, 0, 0, 1, 1, 0, 0, 0, 0, 0));
    rnd = 1'($urandom_range(0, 1));
    push(rnd, z, op, fn, pk(2, 0, 0, 3, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    case (k)
      K_LW, K_SW: begin
        push(1'($urandom_range(0, 1)), z, op, fn, pk(3, 0, 1, 2, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        for (int i = 0; i <= wm; i++) begin
          if (k == K_LW)
            push(i == wm, z, op, fn, pk(4, 0, 0, 0, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0));
          else
            push(i == wm, z, op, fn, pk(6, 0, 0, 0, 1, 1, 1, 0, 0, 0, 0, 0, 0, 0));
        end
        if (k == K_LW)
          push(1'($urandom_range(0, 1)), z, op, fn, pk(5, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 0));
      end
      K_R: begin
        c = r_cmd(fn);
        if (c >= 8)
          push(rnd, z, op, fn, pk(7, 4'(c), 2, 4, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        else
          push(rnd, z, op, fn, pk(7, 4'(c), 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        push(rnd, z, op, fn, pk(8, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0));
      end
      K_I: begin
        case (op)
          6'b001100: push(rnd, z, op, fn, pk(9, 4, 1, 5, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
          6'b001101: push(rnd, z, op, fn, pk(9, 5, 1, 5, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
          6'b001110: push(rnd, z, op, fn, pk(9, 7, 1, 5, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
          default:   push(rnd, z, op, fn, pk(9, 0, 1, 2, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        endcase
        push(rnd, z, op, fn, pk(10, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0));
      end
      K_BR: begin
        pcw = (op == 6'b000100) ? z : ~z;
        push(rnd, z, op, fn, pk(11, 2, 1, 0, 0, 0, 0, 0, pcw, 1, 0, 0, 0, 0));
      end
      K_J: push(rnd, z, op, fn, pk(12, 0, 0, 0, 0, 0, 0, 0, 1, 2, 0, 0, 0, 0));
      default: push(rnd, z, op, fn, pk(13, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1));
    endcase
  endtask

  // Drive each planned cycle on the falling edge and compare just after.
  task automatic run(input int n);
    logic [13:0] s;
    logic [23:0] e;
    for (int i = 0; i < n && exp_q.size() > 0; i++) begin
      s = stim_q.pop_front();
      e = exp_q.pop_front();
      @(negedge clk);
      mem_ready = s[13];
      zero      = s[12];
      opcode    = s[11:6];
      funct     = s[5:0];
      #1;
      check($sformatf("cycle st=%0d", e[23:20]), act, e);
    end
  endtask

  task automatic build_cpi(input logic [5:0] op, input logic [5:0] fn, input logic z,
                           input int cpi);
    build(op, fn, z, 0, 0);
    check_int($sformatf("cpi op=%b", op), exp_q.size(), cpi);
    run(exp_q.size());
  endtask

  logic [5:0] op_tab[10];
  logic [5:0] fn_tab[9];
  int         lw_seq[7];

  initial begin
    op_tab = '{6'b100011, 6'b101011, 6'b000000, 6'b001000, 6'b001100,
               6'b001101, 6'b001110, 6'b000100, 6'b000101, 6'b000010};
    fn_tab = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h27, 6'h26, 6'h00, 6'h03, 6'h02};
    lw_seq = '{1, 2, 3, 4, 4, 4, 5};

    repeat (2) @(negedge clk);
    #1 check("reset outputs", act, 24'h0);
    @(negedge clk);
    rst = 1'b1;
    #1 check("idle after release", act, 24'h0);

    // Fetch with 3 wait states, then reset asserted in the middle of MEM_READ.
    build(6'b100011, 6'h00, 1'b0, 3, 5);
    run(8);
    rst = 1'b0;
    #1 check("reset mid MEM_READ", act, 24'h0);
    exp_q.delete();
    stim_q.delete();
    @(negedge clk);
    rst = 1'b1;
    #1 check("idle after mid reset", act, 24'h0);

    // lw with two memory wait states: model trace pinned to literal states.
    build(6'b100011, 6'h00, 1'b0, 0, 2);
    check_int("lw trace length", exp_q.size(), 7);
    for (int i = 0; i < 7 && i < exp_q.size(); i++)
      check_int($sformatf("lw trace state %0d", i), int'(exp_q[i][23:20]), lw_seq[i]);
    run(exp_q.size());

    build_cpi(6'b000000, 6'b100010, 1'b0, 4);  // sub
    build_cpi(6'b000000, 6'b000011, 1'b0, 4);  // sra
    build_cpi(6'b000100, 6'h00, 1'b1, 3);      // beq taken
    build_cpi(6'b000101, 6'h00, 1'b1, 3);      // bne not taken
    build_cpi(6'b001101, 6'h00, 1'b0, 4);      // ori
    build_cpi(6'b101011, 6'h00, 1'b0, 4);      // sw
    build_cpi(6'b000010, 6'h00, 1'b0, 3);      // j
    build_cpi(6'b100011, 6'h00, 1'b0, 5);      // lw
    build_cpi(6'b111111, 6'h00, 1'b0, 3);      // unsupported opcode
    build_cpi(6'b000000, 6'b101010, 1'b0, 3);  // unsupported funct

    for (int n = 0; n < 250; n++) begin
      logic [5:0] op;
      logic [5:0] fn;
      op = ($urandom_range(0, 3) == 0) ? 6'($urandom) : op_tab[$urandom_range(0, 9)];
      fn = ($urandom_range(0, 3) == 0) ? 6'($urandom) : fn_tab[$urandom_range(0, 8)];
      build(op, fn, 1'($urandom_range(0, 1)),
            ($urandom_range(0, 2) == 0) ? $urandom_range(1, 3) : 0,
            ($urandom_range(0, 2) == 0) ? $urandom_range(1, 3) : 0);
      run(exp_q.size());
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/multicycle_ctrl.md
Name: multicycle_ctrl

Overview:
Main control FSM for the multicycle MIPS core. It is the initiator side of the ALU command interface. Per instruction it sequences fetch, decode, execute, memory and writeback. Each cycle it drives the ALU opcode (cmd), the operand-select muxes, the memory request handshake and the register/PC write enables. The datapath (IR, A/B, ALUOut, MDR, PC) lives outside this block.

Parameters:
ALU_CMD_W, 4, width of alu_cmd; must match the ALU cmd input.

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous, active-low reset
opcode  in  6  IR[31:26], valid from DECODE until the next IR load
funct  in  6  IR[5:0]
zero  in  1  datapath flag, ALU result == 0, valid in BRANCH
mem_ready  in  1  memory completion, may be high in the same cycle as mem_req
alu_cmd  out  4  ALU operation: ADD 0000, SUB 0010, AND 0100, OR 0101, NOR 0110, XOR 0111, SLL 1000, SRA 1001, SRL 1010
alu_src_a  out  2  in1 select: 00 PC, 01 A, 10 B
alu_src_b  out  3  in2 select: 000 B, 001 const 4, 010 sext imm, 011 sext imm<<2, 100 zext shamt, 101 zext imm
mem_req  out  1  memory access request
mem_we  out  1  write qualifier for mem_req
i_or_d  out  1  address select: 0 PC, 1 ALUOut
ir_write  out  1  load IR
pc_write  out  1  load PC
pc_src  out  2  PC source: 00 ALU result, 01 ALUOut, 10 jump target
reg_write  out  1  register file write
reg_dst  out  1  destination: 0 rt, 1 rd
mem_to_reg  out  1  write data: 0 ALUOut, 1 MDR
illegal  out  1  one-cycle pulse on an unsupported instruction
state_out  out  4  current state code, for debug and verification

Behaviour:
- Clock and reset: one clock, clk. rst is asynchronous and active-low. While rst=0, the state is IDLE and every output is 0 (alu_cmd=0000). An assertion mid-instruction drops mem_req immediately; the abandoned access is not resumed.
- Output style: Moore. Outputs decode from the registered state, with two exceptions: ir_write/pc_write in FETCH and pc_write in BRANCH. Any output not listed for a state is 0.
- State codes: IDLE=0, FETCH=1, DECODE=2, MEM_ADDR=3, MEM_READ=4, MEM_WB=5, MEM_WRITE=6, R_EXEC=7, R_WB=8, I_EXEC=9, I_WB=10, BRANCH=11, JUMP=12, ILLEGAL=13. Codes 14/15 go to IDLE.
- IDLE: always goes to FETCH on the next edge.
- FETCH: mem_req=1, i_or_d=0. ALU computes PC+4 (src_a 00, src_b 001, ADD), pc_src=00. ir_write = pc_write = mem_ready. Stays in FETCH until mem_ready=1, then goes to DECODE. A zero-wait fetch takes 1 cycle.
- DECODE: ALU computes PC + sext imm<<2 (src_a 00, src_b 011, ADD) into ALUOut for branches. Next state by opcode:
  - 100011 (lw) or 101011 (sw) -> MEM_ADDR
  - 000000 -> R_EXEC if funct is supported, else ILLEGAL
  - 001000/001100/001101/001110 (addi/andi/ori/xori) -> I_EXEC
  - 000100/000101 (beq/bne) -> BRANCH
  - 000010 (j) -> JUMP
  - any other opcode -> ILLEGAL
- MEM_ADDR: src_a 01, src_b 010, ADD. Goes to MEM_READ for lw, MEM_WRITE for sw.
- MEM_READ: mem_req=1, i_or_d=1. Waits for mem_ready, then goes to MEM_WB.
- MEM_WB: reg_write=1, reg_dst=0, mem_to_reg=1. Goes to FETCH.
- MEM_WRITE: mem_req=1, mem_we=1, i_or_d=1. Waits for mem_ready, then goes to FETCH.
- R_EXEC: funct selects alu_cmd: 100000 ADD, 100010 SUB, 100100 AND, 100101 OR, 100111 NOR, 100110 XOR, 000000 SLL, 000011 SRA, 000010 SRL.
  - Non-shift: src_a 01, src_b 000.
  - Shift: src_a 10, src_b 100.
  - Goes to R_WB.
- R_WB: reg_write=1, reg_dst=1, mem_to_reg=0. Goes to FETCH.
- I_EXEC: src_a 01. addi uses ADD with src_b 010; andi/ori/xori use AND/OR/XOR with src_b 101. Goes to I_WB.
- I_WB: reg_write=1, reg_dst=0, mem_to_reg=0. Goes to FETCH.
- BRANCH: src_a 01, src_b 000, SUB, pc_src=01. pc_write = (beq & zero) | (bne & ~zero). Goes to FETCH.
- JUMP: pc_write=1, pc_src=10. Goes to FETCH.
- ILLEGAL: illegal=1 for exactly one cycle; no write enables asserted. Goes to FETCH.
- CPI with zero-wait memory: lw 5, sw 4, R/I-type 4, branch 3, jump 3. Each wait cycle adds 1.
- mem_ready while mem_req=0 is ignored.

Test Plan:
- Reset and fetch: rst low mid-MEM_READ -> all outputs 0 and state_out=0 immediately. Release -> FETCH on the next edge. With mem_ready held at 0 for 3 cycles, mem_req stays 1, ir_write and pc_write stay 0. Then mem_ready=1 -> ir_write=pc_write=1 for one cycle, then DECODE.
- lw with 2 wait states (opcode 100011): state sequence 1,2,3,4,4,4,5,1. In MEM_WB: reg_write=1, mem_to_reg=1.
- R-type sub (funct 100010), then sra (funct 000011): in R_EXEC, alu_cmd=0010 with src_a 01/src_b 000, then alu_cmd=1001 with src_a 10/src_b 100. R_WB has reg_dst=1.
- beq then bne, each with zero=1: pc_write=1 in BRANCH for beq, 0 for bne. alu_cmd=0010, pc_src=01.
- ori (001101) -> I_EXEC has alu_cmd=0101, src_b 101. sw (101011) -> MEM_WRITE has mem_we=1. j (000010) -> JUMP has pc_write=1, pc_src=10.
- opcode 111111, then R-type funct 101010 -> each reaches ILLEGAL, illegal pulses 1 cycle, reg_write/pc_write/mem_req stay 0, returns to FETCH.
